// File: rtl/param_register_file_if.sv
// Bus interface for param_register_file: read/write ports plus the bulk-clear handshake.
// The controller drives through master; the register file sits on slave.
interface param_register_file_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
);
    logic [ADDR_WIDTH-1:0] read_register1;
    logic [ADDR_WIDTH-1:0] read_register2;
    logic                  write_enable;
    logic [ADDR_WIDTH-1:0] write_register;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  clear_req;
    logic [DATA_WIDTH-1:0] read_data1;
    logic [DATA_WIDTH-1:0] read_data2;
    logic                  write_ack;
    logic                  busy;
    logic                  clear_done;

    modport master (
        output read_register1, read_register2, write_enable, write_register,
               write_data, clear_req,
        input  read_data1, read_data2, write_ack, busy, clear_done
    );

    modport slave (
        input  read_register1, read_register2, write_enable, write_register,
               write_data, clear_req,
        output read_data1, read_data2, write_ack, busy, clear_done
    );
endinterface

// File: rtl/param_register_file.sv
// 2-read/1-write register file with write-to-read bypass and a sequential bulk-clear engine.
// Define REG_FILE_ZERO_REG_EN to hardwire entry 0 to zero.
module param_register_file #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    ADDR_WIDTH  = 3,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input logic                  clock,
    input logic                  reset,
    param_register_file_if.slave bus
);
    localparam int                    DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

`ifdef REG_FILE_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] counter;
    logic [ADDR_WIDTH-1:0] counter_next;
    logic                  clear_done_q;
    logic                  clear_done_next;
    logic [DATA_WIDTH-1:0] entries [DEPTH];
    logic                  write_accept;
    logic                  write_commit;
    logic                  bypass1;
    logic                  bypass2;
    logic [DATA_WIDTH-1:0] clear_value;

    function automatic logic [DATA_WIDTH-1:0] entry_reset(input int idx);
        return (ZERO_REG && idx == 0) ? '0 : RESET_VALUE;
    endfunction

    // A write is acknowledged whenever the engine is idle; the zero register swallows it silently.
    assign write_accept = bus.write_enable && (state == IDLE);
    assign write_commit = write_accept && !(ZERO_REG && bus.write_register == '0);
    assign bypass1      = write_commit && (bus.write_register == bus.read_register1);
    assign bypass2      = write_commit && (bus.write_register == bus.read_register2);
    assign clear_value  = (ZERO_REG && counter == '0) ? '0 : RESET_VALUE;

    assign bus.read_data1 = bypass1 ? bus.write_data :
                            (ZERO_REG && bus.read_register1 == '0) ? '0 :
                            entries[bus.read_register1];
    assign bus.read_data2 = bypass2 ? bus.write_data :
                            (ZERO_REG && bus.read_register2 == '0) ? '0 :
                            entries[bus.read_register2];
    assign bus.write_ack  = write_accept;
    assign bus.busy       = (state == CLEAR);
    assign bus.clear_done = clear_done_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= entry_reset(i);
            end
        end else if (state == CLEAR) begin
            entries[counter] <= clear_value;
        end else if (write_commit) begin
            entries[bus.write_register] <= bus.write_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            counter      <= '0;
            clear_done_q <= 1'b0;
        end else begin
            state        <= state_next;
            counter      <= counter_next;
            clear_done_q <= clear_done_next;
        end
    end

    // Clearing walks one entry per cycle; the counter wrap and the return to IDLE coincide.
    always_comb begin
        state_next      = state;
        counter_next    = counter;
        clear_done_next = 1'b0;
        case (state)
            IDLE: begin
                if (bus.clear_req) begin
                    state_next   = CLEAR;
                    counter_next = '0;
                end
            end
            CLEAR: begin
                counter_next = counter + ADDR_WIDTH'(1);
                if (counter == LAST_ADDR) begin
                    state_next      = IDLE;
                    clear_done_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end
endmodule
